// File: rtl/ws2812_serializer.sv
// ws2812_serializer: streams a frame of NUM_LEDS 24-bit words onto a single
// WS2812 data line. LED 0 goes out first, each word MSB first, and each bit
// is a fixed-length period whose high time encodes the bit value. A low
// latch interval follows every frame.
//
// Build option: define WS2812_AUTO_REFRESH_EN to re-capture bits and resend
// the frame continuously after every latch interval without needing start.
module ws2812_serializer #(
    parameter int NUM_LEDS     = 64,
    parameter int SYS_FREQ_MHZ = 100,
    parameter int PERIOD_NS    = 1250,
    parameter int T1H_NS       = 900,
    parameter int T0H_NS       = 350,
    parameter int LATCH_US     = 60
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_LEDS*24-1:0] bits,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   signal
);

    // Timing expressed in clk cycles
    localparam int PERIOD_CYC = PERIOD_NS * SYS_FREQ_MHZ / 1000;
    localparam int T1H_CYC    = T1H_NS * SYS_FREQ_MHZ / 1000;
    localparam int T0H_CYC    = T0H_NS * SYS_FREQ_MHZ / 1000;
    localparam int LATCH_CYC  = LATCH_US * SYS_FREQ_MHZ;
    localparam int TOTAL_BITS = NUM_LEDS * 24;

    // One counter serves both the bit period and the latch interval
    localparam int CNT_MAX = ((PERIOD_CYC > LATCH_CYC) ? PERIOD_CYC : LATCH_CYC) - 1;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_MAX = TOTAL_BITS - 1;
    localparam int IDX_W   = $clog2(IDX_MAX) + 1;

    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] T1H_LAST    = CNT_W'(T1H_CYC - 1);
    localparam logic [CNT_W-1:0] T0H_LAST    = CNT_W'(T0H_CYC - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST  = CNT_W'(LATCH_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(IDX_MAX);
    localparam logic [4:0]       SEL_MSB     = 5'd23;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [IDX_W-1:0]        bit_idx;
    logic [IDX_W-1:0]        idx_next;
    logic [4:0]              bit_sel;
    logic [4:0]              sel_next;
    logic [TOTAL_BITS-1:0]   frame_q;
    logic [TOTAL_BITS-1:0]   frame_next;
    logic                    signal_next;
    logic                    busy_next;
    logic                    done_next;
    logic [23:0]             led_word;
    logic                    cur_bit;
    logic [CNT_W-1:0]        high_last;

    // The frame register is shifted down one word per LED, so the LED in
    // flight always sits in the low 24 bits and bit_sel walks 23 down to 0.
    assign led_word  = frame_q[23:0];
    assign cur_bit   = led_word[bit_sel];
    assign high_last = cur_bit ? T1H_LAST : T0H_LAST;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counter, bit pointer and frame capture decisions
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = bit_idx;
        sel_next   = bit_sel;
        frame_next = frame_q;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                    idx_next   = '0;
                    sel_next   = SEL_MSB;
                    frame_next = bits;
                end
            end

            HIGH: begin
                cnt_next = cnt + 1'b1;
                if (cnt == high_last) begin
                    state_next = LOW;
                end
            end

            LOW: begin
                if (cnt == PERIOD_LAST) begin
                    cnt_next = '0;
                    if (bit_idx == IDX_LAST) begin
                        state_next = LATCH;
                    end else begin
                        state_next = HIGH;
                        idx_next   = bit_idx + 1'b1;
                        if (bit_sel == 5'd0) begin
                            sel_next   = SEL_MSB;
                            frame_next = frame_q >> 24;
                        end else begin
                            sel_next = bit_sel - 1'b1;
                        end
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            LATCH: begin
                if (cnt == LATCH_LAST) begin
                    cnt_next = '0;
`ifdef WS2812_AUTO_REFRESH_EN
                    state_next = HIGH;
                    idx_next   = '0;
                    sel_next   = SEL_MSB;
                    frame_next = bits;
`else
                    state_next = IDLE;
`endif
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                idx_next   = '0;
                sel_next   = SEL_MSB;
            end
        endcase
    end

    // Outputs are computed from the next state so they come straight off
    // flops and the data line cannot glitch on state decoding.
    always_comb begin
        signal_next = (state_next == HIGH);
        busy_next   = (state_next != IDLE);
        done_next   = (state_next == LATCH) && (cnt_next == LATCH_LAST);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            bit_sel <= '0;
            frame_q <= '0;
            signal  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            bit_idx <= idx_next;
            bit_sel <= sel_next;
            frame_q <= frame_next;
            signal  <= signal_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

endmodule
